// File: rtl/pc_sequencer_pkg.sv
// Shared types for the UnionMagica PC sequencer: PC width, FSM states, and
// the per-cycle action chosen by the priority decoder.
package pc_seq_pkg;

    localparam int PC_W = 11;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } seq_state_e;

    typedef enum logic [2:0] {
        ACT_NONE = 3'd0,
        ACT_INC  = 3'd1,
        ACT_JUMP = 3'd2,
        ACT_CALL = 3'd3,
        ACT_RET  = 3'd4
    } seq_action_e;

    // Sequential successor address; wraps modulo 2^PC_W.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc_val);
        return pc_val + PC_W'(1);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Return-address stack port: the sequencer is the master (strobes, write data),
// the stack is the slave and returns its top-of-stack combinationally.
interface pc_sequencer_if;
    import pc_seq_pkg::*;

    logic            stack_push;
    logic            stack_pop;
    logic [PC_W-1:0] stack_wdata;
    logic [PC_W-1:0] stack_rdata;

    modport master (
        output stack_push,
        output stack_pop,
        output stack_wdata,
        input  stack_rdata
    );

    modport slave (
        input  stack_push,
        input  stack_pop,
        input  stack_wdata,
        output stack_rdata
    );

endinterface

// File: rtl/pc_sequencer_depth_ctr.sv
// Up/down occupancy counter mirroring the return stack depth. With GUARD set
// it saturates at 0 and DEPTH; without it the count wraps modulo 2^CNT_W.
module pc_seq_depth_ctr #(
    parameter  int DEPTH = 3,
    parameter  bit GUARD = 1'b1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [CNT_W-1:0] count_r;

    assign count = count_r;
    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == CNT_W'(0));

    // Occupancy update; simultaneous inc/dec leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= CNT_W'(0);
        end else if (inc && !dec && !(GUARD && full)) begin
            count_r <= count_r + CNT_W'(1);
        end else if (dec && !inc && !(GUARD && empty)) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer driving the return-address stack.
// Optional feature macro: PC_SEQ_STACK_GUARD_EN (overflow/underflow -> FAULT).
import pc_seq_pkg::*;

module pc_sequencer #(
    parameter  int STACK_DEPTH = 3,
    localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step,
    input  logic               op_jump,
    input  logic               op_call,
    input  logic               op_ret,
    input  logic               halt_req,
    input  logic               resume,
    input  logic [PC_W-1:0]    target,
    pc_sequencer_if.master     stk,
    output logic [PC_W-1:0]    pc,
    output logic [DEPTH_W-1:0] depth,
    output logic               halted,
    output logic               fault
);

`ifdef PC_SEQ_STACK_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    seq_state_e  state_r;
    seq_state_e  state_nxt_s;
    seq_action_e action_s;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_nxt_s;
    logic [PC_W-1:0] wdata_r;
    logic            halted_r;
    logic            fault_r;
    logic            push_s;
    logic            pop_s;
    logic            overflow_s;
    logic            underflow_s;
    logic            full_s;
    logic            empty_s;

    // Priority decode of the single action taken this cycle; reset discards it.
    always_comb begin
        action_s = ACT_NONE;
        if (rst_n && step && (state_r == ST_RUN)) begin
            if (halt_req) begin
                action_s = ACT_NONE;
            end else if (op_ret) begin
                action_s = ACT_RET;
            end else if (op_call) begin
                action_s = ACT_CALL;
            end else if (op_jump) begin
                action_s = ACT_JUMP;
            end else begin
                action_s = ACT_INC;
            end
        end else begin
            action_s = ACT_NONE;
        end
    end

    // Strobes are suppressed when the local depth says the stack cannot accept them.
    always_comb begin
        overflow_s  = GUARD_EN && (action_s == ACT_CALL) && full_s;
        underflow_s = GUARD_EN && (action_s == ACT_RET) && empty_s;
        push_s      = (action_s == ACT_CALL) && !overflow_s;
        pop_s       = (action_s == ACT_RET) && !underflow_s;
    end

    // Next PC; a blocked call/return holds the PC.
    always_comb begin
        pc_nxt_s = pc_r;
        case (action_s)
            ACT_INC:  pc_nxt_s = pc_inc(pc_r);
            ACT_JUMP: pc_nxt_s = target;
            ACT_CALL: pc_nxt_s = overflow_s ? pc_r : target;
            ACT_RET:  pc_nxt_s = underflow_s ? pc_r : stk.stack_rdata;
            default:  pc_nxt_s = pc_r;
        endcase
    end

    // Next FSM state; step low freezes every state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (step && halt_req) begin
                    state_nxt_s = ST_HALT;
                end else if (overflow_s || underflow_s) begin
                    state_nxt_s = ST_FAULT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALT: begin
                if (step && resume && !halt_req) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            ST_FAULT: state_nxt_s = ST_FAULT;
            default:  state_nxt_s = ST_RUN;
        endcase
    end

    // State, PC and status registers; return address tracks the next PC so it
    // is already stable during any push cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_RUN;
            pc_r     <= PC_W'(0);
            wdata_r  <= PC_W'(0);
            halted_r <= 1'b0;
            fault_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            pc_r     <= pc_nxt_s;
            wdata_r  <= pc_inc(pc_nxt_s);
            halted_r <= (state_nxt_s == ST_HALT);
            fault_r  <= GUARD_EN && (state_nxt_s == ST_FAULT);
        end
    end

    pc_seq_depth_ctr #(
        .DEPTH (STACK_DEPTH),
        .GUARD (GUARD_EN)
    ) u_depth_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (push_s),
        .dec   (pop_s),
        .count (depth),
        .full  (full_s),
        .empty (empty_s)
    );

    assign pc              = pc_r;
    assign halted          = halted_r;
    assign fault           = fault_r;
    assign stk.stack_push  = push_s;
    assign stk.stack_pop   = pop_s;
    assign stk.stack_wdata = wdata_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer; guard-build expectations are
// selected with PC_SEQ_STACK_GUARD_EN, matching the design build.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    typedef struct {
        string       tag;
        logic [10:0] pc;
        logic [1:0]  depth;
        logic        halted;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        step = 1'b0;
    logic        op_jump = 1'b0;
    logic        op_call = 1'b0;
    logic        op_ret = 1'b0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic [10:0] target = 11'd0;
    logic [10:0] pc;
    logic [1:0]  depth;
    logic        halted;
    logic        fault;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb_q[$];

    pc_sequencer_if stk_if ();

    pc_sequencer #(.STACK_DEPTH(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .step     (step),
        .op_jump  (op_jump),
        .op_call  (op_call),
        .op_ret   (op_ret),
        .halt_req (halt_req),
        .resume   (resume),
        .target   (target),
        .stk      (stk_if.master),
        .pc       (pc),
        .depth    (depth),
        .halted   (halted),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        step = 1'b1; op_call = 1'b1; op_ret = 1'b0; op_jump = 1'b0;
        halt_req = 1'b0; resume = 1'b0; target = 11'd123;
        #1;
        chk("rst_push", 32'(stk_if.stack_push), 32'd0);
        chk("rst_pop", 32'(stk_if.stack_pop), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_wdata", 32'(stk_if.stack_wdata), 32'd0);
    endtask

    task automatic do_step(input string tag,
                           input logic s, input logic hr, input logic rs,
                           input logic rt, input logic cl, input logic jp,
                           input logic [10:0] tgt, input logic [10:0] rd,
                           input logic e_push, input logic e_pop, input logic [10:0] e_wdata,
                           input logic [10:0] e_pc, input logic [1:0] e_depth,
                           input logic e_halted, input logic e_fault);
        exp_t e;
        @(negedge clk);
        rst_n = 1'b1;
        step = s; halt_req = hr; resume = rs;
        op_ret = rt; op_call = cl; op_jump = jp;
        target = tgt; stk_if.stack_rdata = rd;
        #1;
        chk({tag, "_push"}, 32'(stk_if.stack_push), 32'(e_push));
        chk({tag, "_pop"}, 32'(stk_if.stack_pop), 32'(e_pop));
        if (e_push) chk({tag, "_wdata"}, 32'(stk_if.stack_wdata), 32'(e_wdata));
        e = '{tag, e_pc, e_depth, e_halted, e_fault};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({e.tag, "_pc"}, 32'(pc), 32'(e.pc));
        chk({e.tag, "_depth"}, 32'(depth), 32'(e.depth));
        chk({e.tag, "_halted"}, 32'(halted), 32'(e.halted));
        chk({e.tag, "_fault"}, 32'(fault), 32'(e.fault));
    endtask

    initial begin
        stk_if.stack_rdata = 11'd0;
        do_reset();
        //       tag          s  hr rs rt cl jp tgt      rd      push pop wdata   pc       d     h  f
        do_step("inc1",     1, 0, 0, 0, 0, 0, 11'd0,   11'd0,  0, 0, 11'd0,  11'd1,   2'd0, 0, 0);
        do_step("inc2",     1, 0, 0, 0, 0, 0, 11'd0,   11'd0,  0, 0, 11'd0,  11'd2,   2'd0, 0, 0);
        do_step("inc3",     1, 0, 0, 0, 0, 0, 11'd0,   11'd0,  0, 0, 11'd0,  11'd3,   2'd0, 0, 0);
        do_step("inc4",     1, 0, 0, 0, 0, 0, 11'd0,   11'd0,  0, 0, 11'd0,  11'd4,   2'd0, 0, 0);
        do_step("inc5",     1, 0, 0, 0, 0, 0, 11'd0,   11'd0,  0, 0, 11'd0,  11'd5,   2'd0, 0, 0);
        do_step("call100",  1, 0, 0, 0, 1, 0, 11'd100, 11'd0,  1, 0, 11'd6,  11'd100, 2'd1, 0, 0);
        do_step("ret6",     1, 0, 0, 1, 0, 0, 11'd0,   11'd6,  0, 1, 11'd0,  11'd6,   2'd0, 0, 0);
        do_step("nostep",   0, 0, 0, 0, 1, 0, 11'd55,  11'd0,  0, 0, 11'd0,  11'd6,   2'd0, 0, 0);
        do_step("jmp10",    1, 0, 0, 0, 0, 1, 11'd10,  11'd0,  0, 0, 11'd0,  11'd10,  2'd0, 0, 0);
        do_step("call_a",   1, 0, 0, 0, 1, 1, 11'd20,  11'd0,  1, 0, 11'd11, 11'd20,  2'd1, 0, 0);
        do_step("call_b",   1, 0, 0, 0, 1, 0, 11'd30,  11'd0,  1, 0, 11'd21, 11'd30,  2'd2, 0, 0);
        do_step("call_c",   1, 0, 0, 0, 1, 0, 11'd40,  11'd0,  1, 0, 11'd31, 11'd40,  2'd3, 0, 0);
`ifdef PC_SEQ_STACK_GUARD_EN
        do_step("call_ovf", 1, 0, 0, 0, 1, 0, 11'd50,  11'd0,  0, 0, 11'd0,  11'd40,  2'd3, 0, 1);
        do_step("flt_inc",  1, 0, 0, 0, 0, 0, 11'd0,   11'd0,  0, 0, 11'd0,  11'd40,  2'd3, 0, 1);
        do_step("flt_ret",  1, 0, 0, 1, 0, 0, 11'd0,   11'd7,  0, 0, 11'd0,  11'd40,  2'd3, 0, 1);
`else
        do_step("call_ovw", 1, 0, 0, 0, 1, 0, 11'd50,  11'd0,  1, 0, 11'd41, 11'd50,  2'd0, 0, 0);
`endif
        do_reset();
`ifdef PC_SEQ_STACK_GUARD_EN
        do_step("ret_unf",  1, 0, 0, 1, 0, 0, 11'd0,   11'd77, 0, 0, 11'd0,  11'd0,   2'd0, 0, 1);
`else
        do_step("ret_unw",  1, 0, 0, 1, 0, 0, 11'd0,   11'd77, 0, 1, 11'd0,  11'd77,  2'd3, 0, 0);
`endif
        do_reset();
        do_step("jmp_max",  1, 0, 0, 0, 0, 1, 11'd2047, 11'd0, 0, 0, 11'd0,  11'd2047, 2'd0, 0, 0);
        do_step("inc_wrap", 1, 0, 0, 0, 0, 0, 11'd0,   11'd0,  0, 0, 11'd0,  11'd0,   2'd0, 0, 0);
        do_step("jmp_max2", 1, 0, 0, 0, 0, 1, 11'd2047, 11'd0, 0, 0, 11'd0,  11'd2047, 2'd0, 0, 0);
        do_step("call_max", 1, 0, 0, 0, 1, 0, 11'd9,   11'd0,  1, 0, 11'd0,  11'd9,   2'd1, 0, 0);
        do_step("halt_cl",  1, 1, 0, 0, 1, 0, 11'd60,  11'd0,  0, 0, 11'd0,  11'd9,   2'd1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            do_step("halt_hold", 1, 0, 0, 0, 0, 1, 11'd3, 11'd0, 0, 0, 11'd0, 11'd9, 2'd1, 1, 0);
        end
        do_step("halt_both", 1, 1, 1, 0, 0, 0, 11'd0,   11'd0,  0, 0, 11'd0,  11'd9,   2'd1, 1, 0);
        do_step("halt_nost", 0, 0, 1, 0, 0, 0, 11'd0,   11'd0,  0, 0, 11'd0,  11'd9,   2'd1, 1, 0);
        do_step("resume",   1, 0, 1, 0, 0, 0, 11'd0,   11'd0,  0, 0, 11'd0,  11'd9,   2'd1, 0, 0);
        do_step("inc_a",    1, 0, 0, 0, 0, 0, 11'd0,   11'd0,  0, 0, 11'd0,  11'd10,  2'd1, 0, 0);
        do_step("inc_b",    1, 0, 0, 0, 0, 0, 11'd0,   11'd0,  0, 0, 11'd0,  11'd11,  2'd1, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
